// File: rtl/mcp3201_responder.sv
// rtl/mcp3201_responder.sv - MCP3201 12-bit ADC serial output emulator (SPI slave side)
module mcp3201_responder #(
    parameter int SYNC_STAGES = 2,
    parameter bit REPEAT_LSB  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_clk_i,
    input  logic        spi_ssn_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe_o,
    input  logic [11:0] sample_i,
    input  logic        sample_valid_i,
    output logic        sample_ready_o,
    output logic        conv_strb_o,
    output logic        underrun_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_NULL,
        ST_MSB,
        ST_LSB,
        ST_ZERO
    } state_t;

    // Synchronizer chains plus one delay flop each for edge detection.
    // They are deliberately not reset so that a steady pin level produces no
    // spurious edge when reset is released.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ssn_sync;
    logic                   sclk_q;
    logic                   ssn_q;

    // Registered edge pulses
    logic sclk_fall;
    logic ssn_fall;
    logic ssn_rise;

    state_t      state;
    logic [4:0]  fcnt;
    logic [11:0] shift_data;
    logic        hold_full;
    logic [11:0] hold_data;

    // Falling-edge number being entered, and the bit indices it selects
    logic [4:0] fcnt_next;
    logic [3:0] msb_idx;
    logic [3:0] lsb_idx;

    // Oversample the asynchronous SPI pins into the system clock domain
    always_ff @(posedge clock) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
        ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], spi_ssn_i};
        sclk_q    <= sclk_sync[SYNC_STAGES-1];
        ssn_q     <= ssn_sync[SYNC_STAGES-1];
    end

    // Turn level changes into single-cycle pulses; ssn_q is the level aligned with them
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_fall <= 1'b0;
            ssn_fall  <= 1'b0;
            ssn_rise  <= 1'b0;
        end else begin
            sclk_fall <= sclk_q & ~sclk_sync[SYNC_STAGES-1];
            ssn_fall  <= ssn_q & ~ssn_sync[SYNC_STAGES-1];
            ssn_rise  <= ~ssn_q & ssn_sync[SYNC_STAGES-1];
        end
    end

    // Saturating edge count and the shifter bit it addresses
    always_comb begin
        fcnt_next = (fcnt == 5'd31) ? 5'd31 : fcnt + 5'd1;
        msb_idx   = 4'(5'd14 - fcnt_next);
        lsb_idx   = 4'(fcnt_next - 5'd14);
    end

    assign sample_ready_o = ~hold_full;

    // Holding register, conversion start, edge counter and output FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            fcnt          <= 5'd0;
            shift_data    <= 12'd0;
            hold_full     <= 1'b0;
            hold_data     <= 12'd0;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            conv_strb_o   <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            conv_strb_o <= 1'b0;
            underrun_o  <= 1'b0;

            // A conversion start consumes the buffer; otherwise accept a new sample
            if (ssn_fall && hold_full) begin
                shift_data <= hold_data;
                hold_full  <= 1'b0;
            end else if (sample_valid_i && !hold_full) begin
                hold_data <= sample_i;
                hold_full <= 1'b1;
            end

            if (ssn_rise) begin
                // Deselect wins over any coincident clock edge
                state         <= ST_IDLE;
                spi_miso_oe_o <= 1'b0;
                spi_miso_o    <= 1'b0;
            end else if (ssn_fall) begin
                state         <= ST_SAMPLE;
                fcnt          <= 5'd0;
                spi_miso_oe_o <= 1'b0;
                spi_miso_o    <= 1'b0;
                conv_strb_o   <= 1'b1;
                underrun_o    <= ~hold_full;
            end else if (sclk_fall && !ssn_q) begin
                fcnt <= fcnt_next;
                case (state)
                    ST_SAMPLE: begin
                        if (fcnt_next == 5'd2) begin
                            state         <= ST_NULL;
                            spi_miso_oe_o <= 1'b1;
                            spi_miso_o    <= 1'b0;
                        end
                    end
                    ST_NULL: begin
                        state      <= ST_MSB;
                        spi_miso_o <= shift_data[11];
                    end
                    ST_MSB: begin
                        if (fcnt_next == 5'd15) begin
                            if (REPEAT_LSB) begin
                                state      <= ST_LSB;
                                spi_miso_o <= shift_data[1];
                            end else begin
                                state      <= ST_ZERO;
                                spi_miso_o <= 1'b0;
                            end
                        end else begin
                            spi_miso_o <= shift_data[msb_idx];
                        end
                    end
                    ST_LSB: begin
                        if (fcnt_next == 5'd26) begin
                            state      <= ST_ZERO;
                            spi_miso_o <= 1'b0;
                        end else begin
                            spi_miso_o <= shift_data[lsb_idx];
                        end
                    end
                    ST_ZERO: begin
                        spi_miso_o <= 1'b0;
                    end
                    default: begin
                        spi_miso_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp3201_responder.sv
// tb/tb_mcp3201_responder.sv - directed self-checking bench for mcp3201_responder
module tb_mcp3201_responder;

    logic        clock;
    logic        reset;
    logic        spi_clk_i;
    logic        spi_ssn_i;
    logic        spi_miso_o;
    logic        spi_miso_oe_o;
    logic [11:0] sample_i;
    logic        sample_valid_i;
    logic        sample_ready_o;
    logic        conv_strb_o;
    logic        underrun_o;

    int errors = 0;
    int checks = 0;
    int conv_cnt = 0;
    int und_cnt = 0;
    int conv_base;
    int und_base;

    mcp3201_responder #(.SYNC_STAGES(2), .REPEAT_LSB(1'b1)) dut (
        .clock          (clock),
        .reset          (reset),
        .spi_clk_i      (spi_clk_i),
        .spi_ssn_i      (spi_ssn_i),
        .spi_miso_o     (spi_miso_o),
        .spi_miso_oe_o  (spi_miso_oe_o),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .conv_strb_o    (conv_strb_o),
        .underrun_o     (underrun_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe pulse counters, sampled away from the active edge
    always @(negedge clock) begin
        if (conv_strb_o) conv_cnt++;
        if (underrun_o) und_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load(input logic [11:0] v);
        sample_i       = v;
        sample_valid_i = 1'b1;
        tick(1);
        sample_valid_i = 1'b0;
    endtask

    // One SPI clock period (mode 0 idle low), 16 system clocks
    task automatic sclk_period();
        spi_clk_i = 1'b1;
        tick(8);
        spi_clk_i = 1'b0;
        tick(8);
    endtask

    // Run n falling edges; bit [n-k] of the vectors is the value after edge k
    task automatic run_edges(input string tag, input int n, input logic [31:0] exp_miso,
                             input logic [31:0] exp_oe);
        for (int k = 1; k <= n; k++) begin
            sclk_period();
            check($sformatf("%s_e%0d_oe", tag, k), 32'(spi_miso_oe_o), 32'(exp_oe[n-k]));
            check($sformatf("%s_e%0d_miso", tag, k), 32'(spi_miso_o), 32'(exp_miso[n-k]));
        end
    endtask

    initial begin
        reset          = 1'b1;
        spi_clk_i      = 1'b0;
        spi_ssn_i      = 1'b1;
        sample_i       = 12'd0;
        sample_valid_i = 1'b0;
        tick(5);
        check("rst_oe", 32'(spi_miso_oe_o), 32'd0);
        check("rst_miso", 32'(spi_miso_o), 32'd0);
        check("rst_ready", 32'(sample_ready_o), 32'd1);
        check("rst_conv", 32'(conv_strb_o), 32'd0);
        check("rst_und", 32'(underrun_o), 32'd0);
        reset = 1'b0;
        tick(2);

        // Deselected clocking must be ignored
        conv_base = conv_cnt;
        und_base  = und_cnt;
        for (int i = 0; i < 20; i++) sclk_period();
        check("idle_oe", 32'(spi_miso_oe_o), 32'd0);
        check("idle_miso", 32'(spi_miso_o), 32'd0);
        check("idle_ready", 32'(sample_ready_o), 32'd1);
        check("idle_conv_cnt", 32'(conv_cnt - conv_base), 32'd0);
        check("idle_und_cnt", 32'(und_cnt - und_base), 32'd0);

        // Frame 1: 0xA5C, 16 edges
        load(12'hA5C);
        check("f1_ready_low", 32'(sample_ready_o), 32'd0);
        conv_base = conv_cnt;
        und_base  = und_cnt;
        spi_ssn_i = 1'b0;
        tick(10);
        check("f1_conv_cnt", 32'(conv_cnt - conv_base), 32'd1);
        check("f1_und_cnt", 32'(und_cnt - und_base), 32'd0);
        check("f1_ready_back", 32'(sample_ready_o), 32'd1);
        run_edges("f1", 16, 32'({2'b00, 12'hA5C, 1'b0, 1'b1}), 32'({1'b0, 15'h7FFF}));
        check("f1_conv_once", 32'(conv_cnt - conv_base), 32'd1);
        spi_ssn_i = 1'b1;
        tick(10);
        check("f1_end_oe", 32'(spi_miso_oe_o), 32'd0);

        // Frame 2: 0x801 with the LSB-first repeat, 30 edges
        load(12'h801);
        spi_ssn_i = 1'b0;
        tick(10);
        run_edges("f2", 30, 32'({2'b00, 1'b1, 10'b0, 1'b1, 10'b0, 1'b1, 5'b0}),
                  32'({1'b0, 29'h1FFF_FFFF}));
        spi_ssn_i = 1'b1;
        tick(3);
        check("f2_oe_lat3", 32'(spi_miso_oe_o), 32'd1);
        tick(1);
        check("f2_oe_lat4", 32'(spi_miso_oe_o), 32'd0);
        check("f2_miso_off", 32'(spi_miso_o), 32'd0);
        tick(10);

        // Frame 3: underrun re-sends 0x801
        conv_base = conv_cnt;
        und_base  = und_cnt;
        spi_ssn_i = 1'b0;
        tick(3);
        check("f3_conv_lat3", 32'(conv_strb_o), 32'd0);
        tick(1);
        check("f3_conv_lat4", 32'(conv_strb_o), 32'd1);
        check("f3_und_lat4", 32'(underrun_o), 32'd1);
        tick(1);
        check("f3_conv_pulse", 32'(conv_strb_o), 32'd0);
        tick(5);
        check("f3_und_cnt", 32'(und_cnt - und_base), 32'd1);
        run_edges("f3", 14, 32'({2'b00, 12'h801}), 32'({1'b0, 13'h1FFF}));
        spi_ssn_i = 1'b1;
        tick(10);

        // Frame 4: abort after edge 7, then a fresh frame with 0x123
        spi_ssn_i = 1'b0;
        tick(10);
        run_edges("f4a", 7, 32'({2'b00, 5'b10000}), 32'({1'b0, 6'h3F}));
        spi_ssn_i = 1'b1;
        tick(6);
        check("f4a_abort_oe", 32'(spi_miso_oe_o), 32'd0);
        load(12'h123);
        conv_base = conv_cnt;
        und_base  = und_cnt;
        spi_ssn_i = 1'b0;
        tick(10);
        check("f4b_conv_cnt", 32'(conv_cnt - conv_base), 32'd1);
        check("f4b_und_cnt", 32'(und_cnt - und_base), 32'd0);
        run_edges("f4b", 16, 32'({2'b00, 12'h123, 1'b1, 1'b0}), 32'({1'b0, 15'h7FFF}));
        spi_ssn_i = 1'b1;
        tick(10);

        // Frame 5: reset at edge 9 with a second sample buffered
        load(12'h3C7);
        spi_ssn_i = 1'b0;
        tick(10);
        load(12'h5A5);
        check("f5_ready_buffered", 32'(sample_ready_o), 32'd0);
        run_edges("f5", 9, 32'({2'b00, 7'b0011110}), 32'({1'b0, 8'hFF}));
        reset = 1'b1;
        tick(1);
        check("f5_rst_oe", 32'(spi_miso_oe_o), 32'd0);
        check("f5_rst_miso", 32'(spi_miso_o), 32'd0);
        check("f5_rst_ready", 32'(sample_ready_o), 32'd1);
        reset = 1'b0;
        conv_base = conv_cnt;
        und_base  = und_cnt;
        tick(10);
        check("f5_no_spurious_conv", 32'(conv_cnt - conv_base), 32'd0);
        spi_ssn_i = 1'b1;
        tick(10);
        spi_ssn_i = 1'b0;
        tick(4);
        check("f6_conv", 32'(conv_strb_o), 32'd1);
        check("f6_und", 32'(underrun_o), 32'd1);
        tick(6);
        run_edges("f6", 14, 32'd0, 32'({1'b0, 13'h1FFF}));
        spi_ssn_i = 1'b1;
        tick(10);
        check("f6_end_oe", 32'(spi_miso_oe_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcp3201_responder.md
# mcp3201_responder

Clock-domain emulation of the MCP3201 12-bit ADC serial output. It is the slave end of the 3-wire SPI link that our ADC controller drives. The block oversamples the external SPI clock and chip-select, takes 12-bit samples from an upstream source through a one-deep valid/ready buffer, and shifts them out on MISO. It replaces a physical converter in loopback builds and board self-test images.

## Interface
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on spi_clk_i and spi_ssn_i (≥2).
- REPEAT_LSB, 1, 1 = after B0 re-send B1..B11 LSB-first per datasheet; 0 = send zeros instead.

Ports:
- clock  in  1  system clock. Must be ≥8× the SPI clock frequency.
- reset  in  1  reset, synchronous, active-high (clock domain `clock`).
- spi_clk_i  in  1  asynchronous SPI clock from the master; idle level is don't-care.
- spi_ssn_i  in  1  asynchronous chip select, active-low.
- spi_miso_o  out  1  serial data; forced to 0 whenever spi_miso_oe_o = 0.
- spi_miso_oe_o  out  1  MISO output enable; 0 models the high-Z state.
- sample_i  in  12  next conversion result, unsigned.
- sample_valid_i  in  1  sample_i valid.
- sample_ready_o  out  1  holding register empty; a transfer occurs when valid & ready.
- conv_strb_o  out  1  one-cycle pulse when a conversion starts (sample committed to the shifter).
- underrun_o  out  1  one-cycle pulse when a conversion starts with the holding register empty.

## Operation
- Synchronizers: spi_clk_i and spi_ssn_i each pass through SYNC_STAGES flops, then one extra flop for edge detection.
  - sclk_fall = prev 1, current 0.
  - ssn_fall / ssn_rise are defined the same way on the synchronized chip select.
- Holding register: hold_full, hold_data.
  - sample_ready_o = !hold_full.
  - A valid & ready transfer sets hold_full and loads hold_data.
- On ssn_fall (conversion start):
  - If hold_full: shift_data ← hold_data, clear hold_full, pulse conv_strb_o.
  - Else: shift_data keeps its previous value (reset value 0), pulse both conv_strb_o and underrun_o.
  - A handshake in the same cycle cannot occur, because ready was 0 while full.
- Falling-edge counter fcnt (5 bits, saturates at 31):
  - Cleared on ssn_fall.
  - Increments on each sclk_fall while synchronized ssn = 0.
- FSM states, with the state entered on each falling edge, counted after ssn falls:
  - IDLE: oe=0. Entered from reset or on ssn_rise in any state. ssn_fall → SAMPLE.
  - SAMPLE: oe=0 (sampling period). Falling edge 2 → NULL.
  - NULL: oe=1, miso=0. Falling edge 3 → MSB.
  - MSB: falling edges 3..14 drive shift_data[11] down to shift_data[0]. After falling edge 15 → LSB if REPEAT_LSB, else ZERO.
  - LSB: falling edges 15..25 drive shift_data[1] up to shift_data[11]. Falling edge 26 → ZERO.
  - ZERO: oe=1, miso=0 until ssn_rise.
- A sclk_fall in the same cycle as ssn_rise is ignored; ssn_rise wins.
- ssn_fall while not in IDLE cannot occur, since a rise must precede it.
- Rising SPI edges are not used; the master samples on its own rising edges.

## Timing
- Reset values:
  - spi_miso_o=0, spi_miso_oe_o=0, conv_strb_o=0, underrun_o=0.
  - sample_ready_o=1 (hold_full=0); shift_data=0; fcnt=0; state IDLE.
- Reset mid-transfer: everything returns to the reset values on the next clock. A buffered sample is discarded.
- Pin edge to internal edge pulse: SYNC_STAGES+1 clocks.
- Registered outputs (miso, oe, conv_strb_o, underrun_o) change one clock after the edge pulse, i.e. SYNC_STAGES+2 clocks after the pin edge (4 with the default).
- sample_ready_o drops one clock after an accepted handshake.
  - It rises one clock after the conversion start that consumes the sample.
  - The earliest back-to-back load is one clock after that rise.
- A conversion is 15 falling edges for the 12-bit MSB-first result, or 26 with the LSB repeat.

## Test plan
- Reset, then hold ssn high and toggle sclk 20 times → oe=0, miso=0, ready=1, no strobes.
- Load 0xA5C, drop ssn, run 16 sclk periods:
  - conv_strb_o pulses once.
  - oe rises at falling edge 2.
  - Bits at falling edges 2..14 are 0,1,0,1,0,0,1,0,1,1,1,0,0.
  - Falling edge 15 carries B1=0.
  - ready returns to 1.
- REPEAT_LSB=1, sample 0x801, 30 falling edges → edges 15..25 carry B1..B11 = 0,0,0,0,0,0,0,0,0,0,1, then zeros; ssn high → oe=0 within 4 clocks.
- No sample loaded, drop ssn → conv_strb_o and underrun_o pulse together; previous sample 0x801 is re-sent MSB-first.
- Raise ssn after falling edge 7, load 0x123, drop ssn → the new frame restarts at SAMPLE with fcnt=0 and sends 0x123.
- Assert reset at falling edge 9 with a second sample buffered → next clock oe=0, miso=0, ready=1; a following frame with no load underruns and sends 0x000.
